// File: rtl/ksa_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ksa_scheduler
//  Description : RC4 key-scheduling stage. Fills S[n]=n, then performs the
//                256 KSA swaps over a single-port S-RAM using a latched key.
//  Revision    : 1.0 - initial release
// ============================================================================
module ksa_scheduler #(
   parameter int RAM_WIDTH  = 8,
   parameter int RAM_LENGTH = 8,
   parameter int KEY_LENGTH = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [8*KEY_LENGTH-1:0] secret_key,
   input  logic [RAM_WIDTH-1:0]    sOut,
   output logic [RAM_LENGTH-1:0]   sAddr,
   output logic [RAM_WIDTH-1:0]    sIn,
   output logic                    sWren,
   output logic                    busy,
   output logic                    finished
);

   localparam int                    c_KIDX_W    = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
   localparam logic [RAM_LENGTH-1:0] c_I_LAST    = '1;
   localparam logic [c_KIDX_W-1:0]   c_KIDX_LAST = c_KIDX_W'(KEY_LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INIT     = 3'd1,
      READ_SI  = 3'd2,
      CALC_J   = 3'd3,
      READ_SJ  = 3'd4,
      WRITE_SI = 3'd5,
      WRITE_SJ = 3'd6,
      DONE     = 3'd7
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [RAM_LENGTH-1:0]   r_i;
   logic [RAM_LENGTH-1:0]   r_j;
   logic [RAM_WIDTH-1:0]    r_si;
   logic [RAM_WIDTH-1:0]    r_sj;
   logic [8*KEY_LENGTH-1:0] r_key;
   logic [c_KIDX_W-1:0]     r_kidx;
   logic                    r_start_q;
   logic                    w_start_edge;
   logic [7:0]              w_key_byte;
   logic [RAM_LENGTH-1:0]   w_j_next;

   assign w_start_edge = start & ~r_start_q;

   // Key byte selected by the wrapping index; byte 0 sits in the MSBs.
   always_comb begin
      w_key_byte = '0;
      for (int k = 0; k < KEY_LENGTH; k++) begin
         if (r_kidx == c_KIDX_W'(k)) begin
            w_key_byte = r_key[8*(KEY_LENGTH-1-k) +: 8];
         end
      end
   end

   // New j, also used directly as the S[j] read address in CALC_J.
   assign w_j_next = r_j + RAM_LENGTH'(sOut) + RAM_LENGTH'(w_key_byte);

   // State register and start edge detector.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_start_q <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_start_q <= start;
      end
   end

   // Next-state decode and RAM port / status outputs.
   always_comb begin
      w_state_next = r_state;
      sAddr        = '0;
      sIn          = '0;
      sWren        = 1'b0;
      busy         = 1'b1;
      finished     = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_start_edge) begin
               w_state_next = INIT;
            end
         end
         INIT: begin
            sAddr = r_i;
            sIn   = RAM_WIDTH'(r_i);
            sWren = 1'b1;
            if (r_i == c_I_LAST) begin
               w_state_next = READ_SI;
            end
         end
         READ_SI: begin
            sAddr        = r_i;
            w_state_next = CALC_J;
         end
         CALC_J: begin
            sAddr        = w_j_next;
            w_state_next = READ_SJ;
         end
         READ_SJ: begin
            sAddr        = r_j;
            w_state_next = WRITE_SI;
         end
         WRITE_SI: begin
            sAddr        = r_i;
            sIn          = r_sj;
            sWren        = 1'b1;
            w_state_next = WRITE_SJ;
         end
         WRITE_SJ: begin
            sAddr        = r_j;
            sIn          = r_si;
            sWren        = 1'b1;
            w_state_next = (r_i == c_I_LAST) ? DONE : READ_SI;
         end
         DONE: begin
            finished     = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Index, swap operands and key register updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i    <= '0;
         r_j    <= '0;
         r_si   <= '0;
         r_sj   <= '0;
         r_key  <= '0;
         r_kidx <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_edge) begin
                  r_key <= secret_key;
                  r_i   <= '0;
                  r_j   <= '0;
               end
            end
            INIT: begin
               r_i <= r_i + 1'b1;
               if (r_i == c_I_LAST) begin
                  r_j    <= '0;
                  r_kidx <= '0;
               end
            end
            CALC_J: begin
               r_si <= sOut;
               r_j  <= w_j_next;
            end
            READ_SJ: begin
               r_sj <= sOut;
            end
            WRITE_SJ: begin
               r_i    <= r_i + 1'b1;
               r_kidx <= (r_kidx == c_KIDX_LAST) ? '0 : r_kidx + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ksa_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ksa_scheduler
//  Description : Self-checking bench for ksa_scheduler with an S-RAM model
//                and a software RC4 KSA scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ksa_scheduler;

   localparam int c_CYCLE_LIMIT = 4000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] secret_key;
   logic [7:0]  sOut;
   logic [7:0]  sAddr;
   logic [7:0]  sIn;
   logic        sWren;
   logic        busy;
   logic        finished;

   logic [7:0]  mem [256];
   logic [7:0]  exp_q [$];
   int          wlog [$];
   int          n_checks  = 0;
   int          n_pass    = 0;
   int          cyc       = 0;
   int          fin_count = 0;

   ksa_scheduler #(
      .RAM_WIDTH  (8),
      .RAM_LENGTH (8),
      .KEY_LENGTH (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .secret_key (secret_key),
      .sOut       (sOut),
      .sAddr      (sAddr),
      .sIn        (sIn),
      .sWren      (sWren),
      .busy       (busy),
      .finished   (finished)
   );

   always #5 clk = ~clk;

   // Synchronous single-port S-RAM with one-cycle read latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sWren === 1'b1) begin
         mem[sAddr] <= sIn;
      end
      sOut <= mem[sAddr];
   end

   task automatic check_value(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference RC4 KSA; expected final S bytes go onto the scoreboard.
   task automatic push_model(input logic [23:0] key);
      logic [7:0] s [256];
      logic [7:0] kb [3];
      logic [7:0] j;
      logic [7:0] t;
      kb[0] = key[23:16];
      kb[1] = key[15:8];
      kb[2] = key[7:0];
      for (int n = 0; n < 256; n++) s[n] = 8'(n);
      j = 8'd0;
      for (int i = 0; i < 256; i++) begin
         j    = j + s[i] + kb[i % 3];
         t    = s[i];
         s[i] = s[j];
         s[j] = t;
      end
      for (int n = 0; n < 256; n++) exp_q.push_back(s[n]);
   endtask

   // Log every RAM write; on finished, pop the expected S and compare.
   always @(negedge clk) begin : monitor
      int mism;
      if (sWren === 1'b1) begin
         wlog.push_back(int'({sAddr, sIn}));
      end
      if (finished === 1'b1) begin
         fin_count++;
         if (exp_q.size() < 256) begin
            check_value("scoreboard_underflow", exp_q.size(), 256);
         end else begin
            mism = 0;
            for (int n = 0; n < 256; n++) begin
               if (mem[n] !== exp_q.pop_front()) mism++;
            end
            check_value("final_S_mismatches", mism, 0);
         end
      end
   end

   // One full run: edge on start, track until finished, then check timing.
   task automatic run_key(input logic [23:0] key, input bit hold,
                          input bit glitch, input bit key0_checks);
      int c0;
      int lat;
      int busy_low;
      int mism;
      wlog.delete();
      push_model(key);
      @(negedge clk);
      secret_key = key;
      start      = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      secret_key = ~key;
      c0 = cyc;
      check_value("init_first_write", int'({sWren, sAddr}), 'h100);
      busy_low = 0;
      lat      = -1;
      for (int k = 0; k < c_CYCLE_LIMIT; k++) begin
         if (busy !== 1'b1) busy_low++;
         if (finished === 1'b1) begin
            lat = cyc - c0;
            break;
         end
         if (key0_checks && (cyc - c0 == 256)) begin
            check_value("init_write_count", wlog.size(), 256);
            check_value("read_si_after_init", int'({sWren, sAddr}), 0);
            mism = 0;
            for (int n = 0; n < 256; n++) begin
               if (mem[n] !== 8'(n)) mism++;
            end
            check_value("identity_mismatches", mism, 0);
         end
         if (glitch && (cyc - c0 == 700)) start = 1'b0;
         if (glitch && (cyc - c0 == 701)) start = 1'b1;
         @(negedge clk);
      end
      check_value("finished_latency", lat, 1536);
      check_value("busy_low_in_run", busy_low, 0);
      check_value("run_write_count", wlog.size(), 768);
      if (key0_checks) begin
         if (wlog.size() >= 262) begin
            check_value("swap_i1_si", wlog[258], 'h0101);
            check_value("swap_i1_sj", wlog[259], 'h0101);
            check_value("swap_i2_si", wlog[260], 'h0203);
            check_value("swap_i2_sj", wlog[261], 'h0302);
         end else begin
            check_value("swap_log_size", wlog.size(), 262);
         end
      end
      @(negedge clk);
      check_value("idle_after_done", int'({finished, busy, sWren, sAddr}), 0);
   endtask

   initial begin : main
      int w0;
      int f0;
      int busy_hi;
      reset      = 1'b0;
      start      = 1'b0;
      secret_key = 24'h0;
      for (int n = 0; n < 256; n++) mem[n] = 8'hAA;
      repeat (3) @(negedge clk);
      check_value("reset_outputs", int'({busy, finished, sWren, sAddr, sIn}), 0);
      reset = 1'b1;

      // Abort mid-INIT with reset, then confirm silence without a new edge.
      wlog.delete();
      @(negedge clk);
      secret_key = 24'h123456;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_value("abort_swren", int'(sWren), 0);
      check_value("abort_busy", int'(busy), 0);
      check_value("abort_writes", wlog.size(), 101);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      w0 = wlog.size();
      busy_hi = 0;
      repeat (50) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_hi++;
      end
      check_value("post_reset_writes", wlog.size() - w0, 0);
      check_value("post_reset_busy", busy_hi, 0);

      run_key(24'h000000, 1'b0, 1'b0, 1'b1);
      run_key(24'h00033C, 1'b0, 1'b0, 1'b0);

      // start held high with a mid-shuffle re-edge: one run only.
      run_key(24'hA5C3E1, 1'b1, 1'b1, 1'b0);
      f0 = fin_count;
      w0 = wlog.size();
      busy_hi = 0;
      repeat (1460) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_hi++;
      end
      check_value("held_extra_finished", fin_count - f0, 0);
      check_value("held_extra_writes", wlog.size() - w0, 0);
      check_value("held_busy_after", busy_hi, 0);
      start = 1'b0;

      run_key(24'h000001, 1'b0, 1'b0, 1'b0);
      run_key(24'h000002, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      check_value("total_finished", fin_count, 5);
      check_value("scoreboard_left", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ksa_scheduler.md
Name: ksa_scheduler

Overview:
- RC4 key-scheduling stage, directly upstream of the keystream/decrypt stage; owns the shared S-RAM port until it reports finished.
- Sequence: fill S[n]=n for n=0..255, then perform the 256 KSA swaps using a 24-bit secret key.
- On finished, the downstream decrypt stage is started; the top-level key-search controller muxes the S-RAM between stages.

Parameters:
- RAM_WIDTH, 8, S-RAM data width.
- RAM_LENGTH, 8, S-RAM address width; S holds 2^RAM_LENGTH = 256 entries.
- KEY_LENGTH, 3, key bytes used cyclically; key byte index = i mod KEY_LENGTH.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately
- start  in  1  level input; internal rising-edge detect, one registered copy
- secret_key  in  8*KEY_LENGTH  key; byte 0 = bits [23:16] (MSB first), byte 2 = [7:0]; sampled once on accepted start
- sOut  in  RAM_WIDTH  S-RAM read data, valid the cycle after sAddr presented (1-cycle synchronous read)
- sAddr  out  RAM_LENGTH  S-RAM address
- sIn  out  RAM_WIDTH  S-RAM write data
- sWren  out  1  S-RAM write enable
- busy  out  1  high in every state except IDLE
- finished  out  1  one-cycle pulse, S fully scheduled

Behaviour:
- Reset (async, active-low):
  - state=IDLE; i=j=si=sj=0; key register=0; start edge register=0.
  - Outputs: sWren=0, sAddr=0, sIn=0, busy=0, finished=0.
  - Mid-operation reset aborts with no further writes; S contents are undefined until the next full run.
- IDLE:
  - On start rising edge: latch secret_key, i=0, j=0, go to INIT.
  - start held high does not retrigger; start edges while busy are ignored.
- INIT (256 cycles): sAddr=i, sIn=i, sWren=1; i++ each cycle; on i==255 write, i wraps to 0, go to READ_SI.
- Shuffle loop, 5 cycles per i:
  - READ_SI: sAddr=i, sWren=0.
  - CALC_J: si<=sOut; j<=j+sOut+key[i mod KEY_LENGTH] (mod 256, 8-bit wrap); sAddr driven combinationally with the new j.
  - READ_SJ: sj<=sOut; sWren=0.
  - WRITE_SI: sAddr=i, sIn=sj, sWren=1.
  - WRITE_SJ: sAddr=j, sIn=si, sWren=1; i++; if i was 255 go to DONE, else READ_SI.
- DONE: finished=1 for exactly one cycle, busy=1, sWren=0; next state IDLE.
- Boundary conditions:
  - i==j: both writes hit the same address with the same value; S is unchanged.
  - i mod KEY_LENGTH is computed by a wrapping counter 0..KEY_LENGTH-1, not a divider; it resets to 0 at start of the shuffle.
  - All adds are 8-bit modulo; no saturation.
- Latency: INIT entered the cycle after the start edge; first INIT write to finished pulse is 256+1280 = 1536 cycles.
- sWren is high only in INIT, WRITE_SI and WRITE_SJ.
- sIn=0 and sAddr=0 in IDLE and DONE.

Test Plan:
- Reset low mid-INIT (i≈100) -> sWren drops same cycle; busy=0; after release, no write until a new start edge.
- key=0x000000, halt after INIT -> S[n]=n for all n; 256 writes counted; first READ_SI follows the last INIT write.
- key=0x000000, full run -> i=1 self-swap (j=1); i=2: j=3, S[2]=3, S[3]=2; final S matches the software KSA model.
- key=0x00033C, full run -> all 256 bytes of final S match the software RC4 KSA model; finished pulses once, exactly 1536 cycles after the first INIT write.
- start held high 3000 cycles, plus a second edge pulsed mid-shuffle -> exactly one run and one finished pulse; busy stays high throughout the run.
- Two back-to-back runs, keys 0x000001 then 0x000002 -> second result depends only on the second key (INIT fully rewrites S); both match the model.
